// File: rtl/cpu_datapath.sv
// cpu_datapath: execution datapath behind the control unit.
// The datapath has a registered 16-op ALU and a 32 x 8 data memory with a registered read-first port.
// result2 is a mux of registered values, so no path runs from the operand inputs to the output.
// Optional feature: define DATAPATH_ADDR_FAULT_EN to add the addr_fault output.
//   With it, an out-of-range effective address does three things: it suppresses the write,
//   it zeroes the load, and it raises addr_fault.
module cpu_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
`ifdef DATAPATH_ADDR_FAULT_EN
  output logic                  addr_fault,
`endif
  output logic [DATA_WIDTH-1:0] result2,
  output logic                  zero,
  output logic                  carry
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  // ALU opcodes
  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_AND    = 4'h2;
  localparam logic [3:0] OP_OR     = 4'h3;
  localparam logic [3:0] OP_XOR    = 4'h4;
  localparam logic [3:0] OP_NOT    = 4'h5;
  localparam logic [3:0] OP_SHL    = 4'h6;
  localparam logic [3:0] OP_SHR    = 4'h7;
  localparam logic [3:0] OP_PASSA  = 4'h8;
  localparam logic [3:0] OP_PASSB  = 4'h9;
  localparam logic [3:0] OP_INC    = 4'hA;
  localparam logic [3:0] OP_DEC    = 4'hB;
  localparam logic [3:0] OP_SLT    = 4'hC;
  localparam logic [3:0] OP_ADDOFF = 4'hD;
  localparam logic [3:0] OP_RSVD   = 4'hE;
  localparam logic [3:0] OP_NOP    = 4'hF;

  logic [DATA_WIDTH-1:0] alu_q, alu_d;
  logic [DATA_WIDTH-1:0] mem_q, mem_d;
  logic                  zero_q, zero_d;
  logic                  carry_q, carry_d;
  logic [ADDR_BITS-1:0]  mem_idx;
  logic                  mem_we;

  logic [DATA_WIDTH-1:0] mem_array [DEPTH];

  // Widened arithmetic so that carry and borrow fall out of the top bit.
  logic [DATA_WIDTH:0] sum_ab, diff_ab, sum_aoff, inc_a, dec_a;

  assign sum_ab   = {1'b0, operand1} + {1'b0, operand2};
  assign diff_ab  = {1'b0, operand1} - {1'b0, operand2};
  assign sum_aoff = {1'b0, operand1} + {1'b0, offset};
  assign inc_a    = {1'b0, operand1} + {{DATA_WIDTH{1'b0}}, 1'b1};
  assign dec_a    = {1'b0, operand1} - {{DATA_WIDTH{1'b0}}, 1'b1};

`ifdef DATAPATH_ADDR_FAULT_EN
  logic [DATA_WIDTH-1:0] eff_addr;
  logic                  addr_oor;
  logic                  fault_q;

  // The full-width effective address is needed to detect out-of-range accesses.
  always_comb begin
    eff_addr = operand1 + (sel3 ? offset : {DATA_WIDTH{1'b0}});
    mem_idx  = eff_addr[ADDR_BITS-1:0];
    addr_oor = |eff_addr[DATA_WIDTH-1:ADDR_BITS];
    mem_we   = w_r & ~addr_oor;
    mem_d    = addr_oor ? {DATA_WIDTH{1'b0}} : mem_array[mem_idx];
  end

  // The fault flag follows each access: it sets when the address is out of range and clears when it is in range.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= addr_oor;
    end
  end

  assign addr_fault = fault_q;
`else
  // Only the low address bits matter when addresses wrap, so the sum is taken at index width.
  always_comb begin
    mem_idx = operand1[ADDR_BITS-1:0] + (sel3 ? offset[ADDR_BITS-1:0] : {ADDR_BITS{1'b0}});
    mem_we  = w_r;
    mem_d   = mem_array[mem_idx];
  end
`endif

  // ALU next-state: result, carry and zero. NOP and ops without a defined carry hold the current values.
  always_comb begin
    alu_d   = alu_q;
    carry_d = carry_q;
    unique case (opcode)
      OP_ADD: begin
        alu_d   = sum_ab[DATA_WIDTH-1:0];
        carry_d = sum_ab[DATA_WIDTH];
      end
      OP_SUB: begin
        alu_d   = diff_ab[DATA_WIDTH-1:0];
        carry_d = diff_ab[DATA_WIDTH];
      end
      OP_AND:   alu_d = operand1 & operand2;
      OP_OR:    alu_d = operand1 | operand2;
      OP_XOR:   alu_d = operand1 ^ operand2;
      OP_NOT:   alu_d = ~operand1;
      OP_SHL: begin
        alu_d   = {operand1[DATA_WIDTH-2:0], 1'b0};
        carry_d = operand1[DATA_WIDTH-1];
      end
      OP_SHR: begin
        alu_d   = {1'b0, operand1[DATA_WIDTH-1:1]};
        carry_d = operand1[0];
      end
      OP_PASSA: alu_d = operand1;
      OP_PASSB: alu_d = operand2;
      OP_INC: begin
        alu_d   = inc_a[DATA_WIDTH-1:0];
        carry_d = inc_a[DATA_WIDTH];
      end
      OP_DEC: begin
        alu_d   = dec_a[DATA_WIDTH-1:0];
        carry_d = dec_a[DATA_WIDTH];
      end
      OP_SLT:   alu_d = {{(DATA_WIDTH-1){1'b0}}, (operand1 < operand2)};
      OP_ADDOFF: begin
        alu_d   = sum_aoff[DATA_WIDTH-1:0];
        carry_d = sum_aoff[DATA_WIDTH];
      end
      OP_RSVD:  alu_d = {DATA_WIDTH{1'b0}};
      OP_NOP:   alu_d = alu_q;
      default:  alu_d = alu_q;
    endcase
    zero_d = (opcode == OP_NOP) ? zero_q : (alu_d == {DATA_WIDTH{1'b0}});
  end

  // ALU, flag and load registers. Reset is asynchronous and does not touch memory contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      mem_q   <= '0;
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
    end else begin
      alu_q   <= alu_d;
      mem_q   <= mem_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  // Memory write port. Gating on rst suppresses any write on an edge that occurs while reset is held.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_array[mem_idx] <= operand2;
    end
  end

  // Output mux over registered sources only.
  assign result2 = sel1 ? alu_q : mem_q;
  assign zero    = zero_q;
  assign carry   = carry_q;

endmodule
